// File: rtl/tia_pkg.sv
// Shared constants, phase-FSM states and the LFSR step rule for the TIA
// horizontal counter.
package tia_pkg;

   localparam int         TIA_HC_W    = 6;
   localparam logic [5:0] TIA_HC_TERM = 6'b001010;

   // Which biphase phase the counter is waiting for next.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      W_P1 = 2'd1,
      W_P2 = 2'd2
   } tia_phase_t;

   // One step of the 6-bit polynomial counter (XNOR feedback of bits 5 and 4).
   function automatic logic [TIA_HC_W-1:0] lfsr_step(input logic [TIA_HC_W-1:0] s);
      return {s[4:0], ~(s[5] ^ s[4])};
   endfunction

endpackage

// File: rtl/tia_biphase_edge.sv
// Rising-edge detector for the two biphase levels, plus an overlap flag
// that flags both phases high or both rising together.
module tia_biphase_edge (
   input  logic clk,
   input  logic r,
   input  logic phi1,
   input  logic phi2,
   output logic p1r,
   output logic p2r,
   output logic overlap
);

   logic [1:0] phase_in;
   logic [1:0] phase_d;
   logic [1:0] phase_q;
   logic [1:0] rise;

   assign phase_in = {phi2, phi1};

   // Previous levels are always the current levels of the last clk.
   always_comb begin
      phase_d = phase_in;
   end

   // Delay register for both phases.
   always_ff @(posedge clk or posedge r) begin
      if (r) begin
         phase_q <= 2'b00;
      end else begin
         phase_q <= phase_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rise
         assign rise[gi] = phase_in[gi] & ~phase_q[gi];
      end
   endgenerate

   assign p1r     = rise[0];
   assign p2r     = rise[1];
   assign overlap = (phi1 & phi2) | (rise[0] & rise[1]);

endmodule

// File: rtl/tia_biphase_counter.sv
// Master/slave polynomial horizontal counter driven by the TIA biphase
// clock: phi1 loads the master, phi2 copies it to the visible slave.
// Flags each wrap to zero and latches any biphase protocol violation.
module tia_biphase_counter
   import tia_pkg::*;
#(
   parameter logic [5:0] TERM = TIA_HC_TERM,
   parameter int         W    = TIA_HC_W
) (
   input  logic         clk,
   input  logic         r,
   input  logic         phi1,
   input  logic         phi2,
   input  logic         rl,
   output logic [W-1:0] cnt,
   output logic         wrap,
   output logic         err
);

   logic p1r;
   logic p2r;
   logic overlap;

   tia_phase_t   state_q,  state_d;
   logic [W-1:0] master_q, master_d;
   logic [W-1:0] slave_q,  slave_d;
   logic         wrap_q,   wrap_d;
   logic         err_q,    err_d;

   tia_biphase_edge u_edge (
      .clk     (clk),
      .r       (r),
      .phi1    (phi1),
      .phi2    (phi2),
      .p1r     (p1r),
      .p2r     (p2r),
      .overlap (overlap)
   );

   // Phase sequencing, counter load/transfer, wrap detect and error capture.
   always_comb begin
      state_d  = state_q;
      master_d = master_q;
      slave_d  = slave_q;
      wrap_d   = 1'b0;
      err_d    = err_q;
      if (rl) begin
         // Latched reset holds the counter at zero; a prior error stays visible.
         master_d = '0;
         slave_d  = '0;
         state_d  = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = W_P1;
            end
            W_P1: begin
               if (overlap || p2r) begin
                  err_d = 1'b1;
               end else if (p1r) begin
                  master_d = (slave_q == TERM) ? '0 : lfsr_step(slave_q);
                  state_d  = W_P2;
               end
            end
            W_P2: begin
               if (overlap || p1r) begin
                  err_d   = 1'b1;
                  state_d = W_P1;
               end else if (p2r) begin
                  slave_d = master_q;
                  wrap_d  = (master_q == '0) && (slave_q == TERM);
                  state_d = W_P1;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk or posedge r) begin
      if (r) begin
         state_q  <= IDLE;
         master_q <= '0;
         slave_q  <= '0;
         wrap_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         master_q <= master_d;
         slave_q  <= slave_d;
         wrap_q   <= wrap_d;
         err_q    <= err_d;
      end
   end

   assign cnt  = slave_q;
   assign wrap = wrap_q;
   assign err  = err_q;

endmodule
